cia_bus_arbiter: RTL

- Shares the single register bus of the on-board 6526 CIA between two requesters: the 6502 CPU bridge and the host/debug bridge.
- Generates the phi2 strobe for the CIA.
- Issues each CIA access as exactly one clk cycle of cs_n low, aligned to the phi2 phase, so CIA side effects fire once per access (ICR read-clear, SDR write-start).
- Returns read data and a one-cycle ack to the requester that won the access.

---
 rtl/cia_bus_pkg.sv | 39 +++
 rtl/phi2_phase_gen.sv | 41 ++++
 rtl/cia_bus_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cia_bus_pkg.sv
// Shared types and constants for the CIA register-bus arbiter.
package cia_bus_pkg;

  // Wide enough for the largest legal phi2 divider (255).
  localparam int PHASE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    ACK
  } state_e;

  typedef enum logic {
    CPU,
    HOST
  } grant_e;

  // Interrupt control register: reading it clears the CIA's pending flags.
  localparam logic [3:0] CIA_RS_ICR = 4'hD;

  // Phase slot of each access step within one phi2 period.
  localparam logic [PHASE_W-1:0] PH_GRANT   = 8'd0;
  localparam logic [PHASE_W-1:0] PH_ISSUE   = 8'd1;
  localparam logic [PHASE_W-1:0] PH_CAPTURE = 8'd2;
  localparam logic [PHASE_W-1:0] PH_ACK     = 8'd3;

  // Round-robin pick: a lone requester wins, a tie goes to whoever
  // did not win last time.
  function automatic grant_e pick_winner(input logic   cpu_req,
                                         input logic   host_req,
                                         input grant_e last_grant);
    if (cpu_req && host_req) begin
      return (last_grant == CPU) ? HOST : CPU;
    end
    return host_req ? HOST : CPU;
  endfunction

endpackage

// File: rtl/phi2_phase_gen.sv
// Phase counter (0..CLK_DIV-1) and a registered one-clk phi2 pulse that is
// high exactly while the counter reads 0.
module phi2_phase_gen
  import cia_bus_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PHASE_W-1:0] phase_o,
  output logic               phi2_o
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_DIV - 1);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic               phi2_q;

  // Next phase: wrap to 0 after the last clk of the period.
  always_comb begin
    phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
  end

  // Advance the phase and pre-compute phi2 for the cycle that will be phase 0.
  // NOTE: state is updated with <= so every register samples the values from
  // before the edge; blocking = here would make results depend on statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      phi2_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      phi2_q  <= (phase_d == '0);
    end
  end

  assign phase_o = phase_q;
  assign phi2_o  = phi2_q;

endmodule

// File: rtl/cia_bus_arbiter.sv
// Arbitrates the single 6526 CIA register bus between the CPU bridge and the
// host/debug bridge. Each access takes one phi2 period: grant at phase 0,
// a single-clk chip select at phase 1, read capture at phase 2, ack at phase 3.
module cia_bus_arbiter
  import cia_bus_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       phi2,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [3:0] cpu_rs,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ack,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [3:0] host_rs,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       host_ack,
  input  logic       host_icr_en,
  output logic       cia_cs_n,
  output logic       cia_rw,
  output logic [3:0] cia_rs,
  output logic [7:0] cia_db_in,
  input  logic [7:0] cia_db_out,
  output logic       busy
);

  logic [PHASE_W-1:0] phase;

  phi2_phase_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_gen (
    .clk    (clk),
    .reset  (reset),
    .phase_o(phase),
    .phi2_o (phi2)
  );

  state_e     state_q;
  grant_e     last_grant_q;
  grant_e     grant_q;
  logic       blocked_q;
  logic       cs_n_q;
  logic       rw_q;
  logic [3:0] rs_q;
  logic [7:0] db_in_q;
  logic [7:0] cpu_rdata_q;
  logic [7:0] host_rdata_q;
  logic       cpu_ack_q;
  logic       host_ack_q;
  logic       busy_q;

  grant_e     grant_d;
  logic       we_d;
  logic [3:0] rs_d;
  logic [7:0] wdata_d;
  logic       blocked_d;

  // Select the would-be winner and its bus fields for the next grant slot.
  // NOTE: every output of this block is assigned on every path, so no latch
  // is inferred.
  always_comb begin
    grant_d   = pick_winner(cpu_req, host_req, last_grant_q);
    we_d      = (grant_d == CPU) ? cpu_we     : host_we;
    rs_d      = (grant_d == CPU) ? cpu_rs     : host_rs;
    wdata_d   = (grant_d == CPU) ? cpu_wdata  : host_wdata;
    // A host ICR read without permission must not touch the CIA at all,
    // since the read itself would clear pending interrupt flags.
    blocked_d = (grant_d == HOST) && !host_we && (host_rs == CIA_RS_ICR) && !host_icr_en;
  end

  // Access sequencer: one step per phase, all bus and handshake outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= HOST;
      grant_q      <= CPU;
      blocked_q    <= 1'b0;
      cs_n_q       <= 1'b1;
      rw_q         <= 1'b1;
      rs_q         <= '0;
      db_in_q      <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((phase == PH_GRANT) && (cpu_req || host_req)) begin
            state_q      <= ISSUE;
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            blocked_q    <= blocked_d;
            cs_n_q       <= blocked_d;
            rw_q         <= ~we_d;
            rs_q         <= rs_d;
            db_in_q      <= wdata_d;
            busy_q       <= 1'b1;
          end
        end
        ISSUE: begin
          if (phase == PH_ISSUE) begin
            cs_n_q  <= 1'b1;
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (phase == PH_CAPTURE) begin
            if (rw_q) begin
              if (grant_q == CPU) begin
                cpu_rdata_q <= cia_db_out;
              end else begin
                host_rdata_q <= blocked_q ? 8'h00 : cia_db_out;
              end
            end
            if (grant_q == CPU) begin
              cpu_ack_q <= 1'b1;
            end else begin
              host_ack_q <= 1'b1;
            end
            state_q <= ACK;
          end
        end
        ACK: begin
          if (phase == PH_ACK) begin
            cpu_ack_q  <= 1'b0;
            host_ack_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cia_cs_n   = cs_n_q;
  assign cia_rw     = rw_q;
  assign cia_rs     = rs_q;
  assign cia_db_in  = db_in_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign host_ack   = host_ack_q;
  assign busy       = busy_q;

endmodule
